// File: rtl/tbird_pkg.sv
// Shared definitions for the Thunderbird tail-light monitor: state encoding,
// lamp patterns, mode/err codes and the pattern decoder.
package tbird_pkg;

  // DF..HZ match the transmitter encoding; SYNC exists only on the receive side
  typedef enum logic [3:0] {
    ST_DF   = 4'd0,
    ST_L0   = 4'd1,
    ST_L1   = 4'd2,
    ST_L2   = 4'd3,
    ST_R0   = 4'd4,
    ST_R1   = 4'd5,
    ST_R2   = 4'd6,
    ST_HZ   = 4'd7,
    ST_SYNC = 4'd8
  } st_e;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_0   = 3'b001;
  localparam logic [2:0] LAMP_1   = 3'b011;
  localparam logic [2:0] LAMP_2   = 3'b111;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_HAZ   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_PATTERN = 2'd1,
    ERR_MOVE    = 2'd2
  } err_code_e;

  typedef struct packed {
    logic ill;
    st_e  st;
  } dec_t;

  function automatic dec_t decode(input logic [2:0] l, input logic [2:0] r);
    dec_t d;
    d.ill = 1'b0;
    d.st  = ST_DF;
    case ({l, r})
      {LAMP_OFF, LAMP_OFF}: d.st = ST_DF;
      {LAMP_0,   LAMP_OFF}: d.st = ST_L0;
      {LAMP_1,   LAMP_OFF}: d.st = ST_L1;
      {LAMP_2,   LAMP_OFF}: d.st = ST_L2;
      {LAMP_OFF, LAMP_0  }: d.st = ST_R0;
      {LAMP_OFF, LAMP_1  }: d.st = ST_R1;
      {LAMP_OFF, LAMP_2  }: d.st = ST_R2;
      {LAMP_2,   LAMP_2  }: d.st = ST_HZ;
      default:              d.ill = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tbird_pattern_decoder_if.sv
// Lamp-sample inputs and monitor results of the tail-light pattern decoder.
interface tbird_pattern_decoder_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [2:0]       L;
  logic [2:0]       R;
  logic [1:0]       mode;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] left_cnt;
  logic [CNT_W-1:0] right_cnt;
  logic [CNT_W-1:0] haz_cnt;

  modport master (
    output en, L, R,
    input  mode, err, err_code, left_cnt, right_cnt, haz_cnt
  );

  modport slave (
    input  en, L, R,
    output mode, err, err_code, left_cnt, right_cnt, haz_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] q
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      q <= '0;
    else if (en && inc)
      q <= sat_inc(q);
  end

endmodule

// File: rtl/tbird_pattern_decoder.sv
// Receive-side checker for the tail-light lamps: rebuilds the transmitter
// state from sampled lamps, reports mode, counts sweeps and flags violations.
module tbird_pattern_decoder
  import tbird_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int IDLE_TICKS = 2
) (
  input logic                  clk,
  input logic                  resetn,
  tbird_pattern_decoder_if.slave bus
);

  logic [2:0] l_p0;
  logic [2:0] r_p0;
  dec_t       obs;
  logic       obs_df;

  st_e        st_p1, st_nxt;
  mode_e      mode_p1, mode_nxt;
  logic       err_p1, err_nxt;
  err_code_e  err_code_p1, err_code_nxt;
  logic [7:0] idle_run_p1, idle_nxt;
  logic       left_inc, right_inc, haz_inc;

  logic [CNT_W-1:0] left_cnt, right_cnt, haz_cnt;

  function automatic logic [7:0] idle_inc(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  function automatic logic move_ok(input st_e cur, input st_e nxt);
    case (cur)
      ST_DF:   return nxt inside {ST_DF, ST_L0, ST_R0, ST_HZ};
      ST_L0:   return nxt inside {ST_L1, ST_HZ};
      ST_L1:   return nxt inside {ST_L2, ST_HZ};
      ST_L2:   return nxt inside {ST_DF, ST_HZ};
      ST_R0:   return nxt inside {ST_R1, ST_HZ};
      ST_R1:   return nxt inside {ST_R2, ST_HZ};
      ST_R2:   return nxt inside {ST_DF, ST_HZ};
      ST_HZ:   return nxt == ST_DF;
      default: return 1'b0;
    endcase
  endfunction

  // ---- stage p0: lamp input register (data only, free-running) ----
  always_ff @(posedge clk) begin
    l_p0 <= bus.L;
    r_p0 <= bus.R;
  end

  assign obs    = decode(l_p0, r_p0);
  assign obs_df = !obs.ill && (obs.st == ST_DF);

  // ---- stage p1: state tracking, mode, error and counter update ----
  always_comb begin
    st_nxt       = st_p1;
    mode_nxt     = mode_p1;
    err_nxt      = 1'b0;
    err_code_nxt = err_code_p1;
    idle_nxt     = idle_run_p1;
    left_inc     = 1'b0;
    right_inc    = 1'b0;
    haz_inc      = 1'b0;

    if (bus.en) begin
      idle_nxt = obs_df ? idle_inc(idle_run_p1) : 8'd0;

      if (obs.ill) begin
        err_nxt      = 1'b1;
        err_code_nxt = ERR_PATTERN;
        st_nxt       = ST_SYNC;
      end else if (st_p1 == ST_SYNC) begin
        // Only an all-off sample re-anchors us; anything else is ignored quietly
        if (obs.st == ST_DF)
          st_nxt = ST_DF;
      end else begin
        st_nxt = obs.st;
        if (move_ok(st_p1, obs.st)) begin
          left_inc  = (st_p1 == ST_L1) && (obs.st == ST_L2);
          right_inc = (st_p1 == ST_R1) && (obs.st == ST_R2);
          haz_inc   = (obs.st == ST_HZ);
        end else begin
          err_nxt      = 1'b1;
          err_code_nxt = ERR_MOVE;
        end
        case (obs.st)
          ST_L0:   mode_nxt = MODE_LEFT;
          ST_R0:   mode_nxt = MODE_RIGHT;
          ST_HZ:   mode_nxt = MODE_HAZ;
          default: ;
        endcase
      end

      if (obs_df && (idle_nxt == 8'(IDLE_TICKS)))
        mode_nxt = MODE_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_p1       <= ST_DF;
      mode_p1     <= MODE_IDLE;
      err_p1      <= 1'b0;
      err_code_p1 <= ERR_NONE;
      idle_run_p1 <= 8'd0;
    end else begin
      st_p1       <= st_nxt;
      mode_p1     <= mode_nxt;
      err_p1      <= err_nxt;
      err_code_p1 <= err_code_nxt;
      idle_run_p1 <= idle_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_left_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en     (bus.en),
    .inc    (left_inc),
    .q      (left_cnt)
  );

  sat_counter #(.W(CNT_W)) u_right_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en     (bus.en),
    .inc    (right_inc),
    .q      (right_cnt)
  );

  sat_counter #(.W(CNT_W)) u_haz_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en     (bus.en),
    .inc    (haz_inc),
    .q      (haz_cnt)
  );

  assign bus.mode      = mode_p1;
  assign bus.err       = err_p1;
  assign bus.err_code  = err_code_p1;
  assign bus.left_cnt  = left_cnt;
  assign bus.right_cnt = right_cnt;
  assign bus.haz_cnt   = haz_cnt;

endmodule

// File: tb/tb_tbird_pattern_decoder.sv
// Directed bench for tbird_pattern_decoder: a CNT_W=8 and a CNT_W=2 instance
// share clock, reset and lamp stimulus.
module tb_tbird_pattern_decoder;
  import tbird_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tbird_pattern_decoder_if #(.CNT_W(8)) bus8 ();
  tbird_pattern_decoder_if #(.CNT_W(2)) bus2 ();

  tbird_pattern_decoder #(.CNT_W(8), .IDLE_TICKS(2)) dut8 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus8)
  );

  tbird_pattern_decoder #(.CNT_W(2), .IDLE_TICKS(2)) dut2 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input int m, input int e, input int c);
    chk({tag, " mode"},     32'(bus8.mode),     m);
    chk({tag, " err"},      32'(bus8.err),      e);
    chk({tag, " err_code"}, 32'(bus8.err_code), c);
  endtask

  task automatic set_lamps(input logic [2:0] l, input logic [2:0] r);
    bus8.L = l;  bus8.R = r;
    bus2.L = l;  bus2.R = r;
  endtask

  task automatic set_en(input logic e);
    bus8.en = e;
    bus2.en = e;
  endtask

  // Called at a negedge: present lamps, let them register, then one en cycle
  task automatic step(input logic [2:0] l, input logic [2:0] r);
    set_lamps(l, r);
    set_en(1'b0);
    @(negedge clk);
    set_en(1'b1);
    @(negedge clk);
    set_en(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    set_lamps(3'b000, 3'b000);
    set_en(1'b0);
    repeat (3) @(negedge clk);

    chk_status("reset", 0, 0, 0);
    chk("reset st",        32'(dut8.st_p1),     32'(ST_DF));
    chk("reset left_cnt",  32'(bus8.left_cnt),  0);
    chk("reset right_cnt", 32'(bus8.right_cnt), 0);
    chk("reset haz_cnt",   32'(bus8.haz_cnt),   0);
    resetn = 1'b1;
    @(negedge clk);

    // Test 1: left sweep
    step(3'b000, 3'b000);
    step(3'b001, 3'b000);
    chk_status("t1 L0", 1, 0, 0);
    step(3'b011, 3'b000);
    step(3'b111, 3'b000);
    chk("t1 left_cnt L2", 32'(bus8.left_cnt), 1);
    step(3'b000, 3'b000);
    chk_status("t1 end", 1, 0, 0);
    chk("t1 left_cnt", 32'(bus8.left_cnt), 1);
    step(3'b000, 3'b000);
    chk_status("t1 idle", 0, 0, 0);

    // Test 2: hazard flashes; single DF between flashes keeps HAZ
    for (int i = 0; i < 3; i++) begin
      step(3'b111, 3'b111);
      chk("t2 mode HZ", 32'(bus8.mode), 3);
      step(3'b000, 3'b000);
      chk("t2 mode DF", 32'(bus8.mode), 3);
    end
    chk("t2 haz_cnt",   32'(bus8.haz_cnt), 3);
    chk("t2 haz_cnt w2", 32'(bus2.haz_cnt), 3);
    step(3'b000, 3'b000);
    chk("t2 mode idle", 32'(bus8.mode), 0);
    step(3'b000, 3'b000);
    chk_status("t2 idle hold", 0, 0, 0);

    // Test 3: DF -> L1 skips L0
    step(3'b011, 3'b000);
    chk_status("t3 skip", 0, 1, 2);
    chk("t3 st", 32'(dut8.st_p1), 32'(ST_L1));
    step(3'b111, 3'b000);
    chk_status("t3 L2", 0, 0, 2);
    chk("t3 left_cnt", 32'(bus8.left_cnt), 2);
    step(3'b000, 3'b000);

    // Test 4: illegal pattern, SYNC behaviour, HZ -> L0
    step(3'b101, 3'b000);
    chk_status("t4 illegal", 0, 1, 1);
    chk("t4 st sync", 32'(dut8.st_p1), 32'(ST_SYNC));
    step(3'b001, 3'b000);
    chk_status("t4 sync ignore", 0, 0, 1);
    chk("t4 st still sync", 32'(dut8.st_p1), 32'(ST_SYNC));
    step(3'b010, 3'b000);
    chk_status("t4 illegal in sync", 0, 1, 1);
    step(3'b000, 3'b000);
    chk("t4 st DF", 32'(dut8.st_p1), 32'(ST_DF));
    chk("t4 err after DF", 32'(bus8.err), 0);
    step(3'b111, 3'b111);
    chk("t4 haz_cnt", 32'(bus8.haz_cnt), 4);
    step(3'b001, 3'b000);
    chk_status("t4 HZ to L0", 1, 1, 2);
    chk("t4 st L0", 32'(dut8.st_p1), 32'(ST_L0));
    chk("t4 haz_cnt w2 sat", 32'(bus2.haz_cnt), 3);
    step(3'b011, 3'b000);
    step(3'b111, 3'b000);
    chk("t4 left_cnt", 32'(bus8.left_cnt), 3);
    chk("t4 left_cnt w2", 32'(bus2.left_cnt), 3);
    step(3'b000, 3'b000);

    // Test 5: five right sweeps, narrow counter saturates
    for (int i = 0; i < 5; i++) begin
      step(3'b000, 3'b001);
      step(3'b000, 3'b011);
      step(3'b000, 3'b111);
      chk("t5 err R2", 32'(bus8.err), 0);
      step(3'b000, 3'b000);
    end
    chk_status("t5 end", 2, 0, 2);
    chk("t5 right_cnt w8", 32'(bus8.right_cnt), 5);
    chk("t5 right_cnt w2", 32'(bus2.right_cnt), 3);

    // Test 6: asynchronous reset mid-sweep with en high
    step(3'b001, 3'b000);
    step(3'b011, 3'b000);
    chk("t6 st L1", 32'(dut8.st_p1), 32'(ST_L1));
    set_en(1'b1);
    #2 resetn = 1'b0;
    #1;
    chk_status("t6 async reset", 0, 0, 0);
    chk("t6 st", 32'(dut8.st_p1), 32'(ST_DF));
    chk("t6 left_cnt", 32'(bus8.left_cnt), 0);
    chk("t6 right_cnt", 32'(bus8.right_cnt), 0);
    chk("t6 haz_cnt", 32'(bus8.haz_cnt), 0);
    @(negedge clk);
    chk("t6 reset wins st", 32'(dut8.st_p1), 32'(ST_DF));
    chk("t6 reset wins err", 32'(bus8.err), 0);
    set_en(1'b0);
    set_lamps(3'b001, 3'b000);
    @(negedge clk);
    resetn = 1'b1;
    step(3'b001, 3'b000);
    chk_status("t6 L0 after reset", 1, 0, 0);
    chk("t6 st L0", 32'(dut8.st_p1), 32'(ST_L0));
    step(3'b011, 3'b000);
    step(3'b111, 3'b000);
    chk("t6 left_cnt after", 32'(bus8.left_cnt), 1);
    chk("t6 left_cnt w2 after", 32'(bus2.left_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
